// File: rtl/i2c_master.sv
// Single-byte I2C master: START, address+rw, ack, one data byte, ack/nack, STOP.
// SCL/SDA are registered open-drain levels derived from the next state.
module i2c_master #(
  parameter int CLK_DIV = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       SDA_in,
  output logic       SDA_out,
  output logic       SCL_out,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [6:0] addr,
  input  logic       rw,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       done,
  output logic       ack_error,
  output logic       busy
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [3:0] {
    IDLE, START, ADDR, ADDR_ACK, WRITE,
    WRITE_ACK, READ, READ_NACK, STOP
  } state_t;

  state_t          state, ns;
  logic [CW-1:0]   cnt, ncnt;
  logic [1:0]      q, nq;
  logic [2:0]      bitc, nbit;
  logic [6:0]      addr_q;
  logic            rw_q;
  logic [7:0]      data_q;
  logic [7:0]      rx;
  logic [7:0]      abyte;
  logic            sda_m, sda_s;
  logic            last_clk, slot_end, smp, accept;
  logic            scl_n, sda_n;

  assign cmd_ready = (state == IDLE) && !done;
  assign busy      = ~cmd_ready;
  assign accept    = cmd_valid && cmd_ready;
  assign last_clk  = (cnt == CW'(CLK_DIV - 1));
  assign slot_end  = last_clk && (q == 2'd3);
  assign smp       = last_clk && (q == 2'd2);
  assign abyte     = {addr_q, rw_q};

  always_comb begin
    ns   = state;
    nq   = q;
    ncnt = cnt;
    nbit = bitc;
    if (state == IDLE) begin
      if (accept) begin
        ns   = START;
        nq   = 2'd0;
        ncnt = '0;
        nbit = 3'd0;
      end
    end else begin
      ncnt = last_clk ? '0 : cnt + 1'b1;
      nq   = last_clk ? q + 2'd1 : q;
      if (slot_end) begin
        nbit = bitc + 3'd1;
        unique case (state)
          START:     begin ns = ADDR; nbit = 3'd0; end
          ADDR:      if (bitc == 3'd7) ns = ADDR_ACK;
          ADDR_ACK: begin
            nbit = 3'd0;
            ns   = ack_error ? STOP : (rw_q ? READ : WRITE);
          end
          WRITE:     if (bitc == 3'd7) ns = WRITE_ACK;
          WRITE_ACK: ns = STOP;
          READ:      if (bitc == 3'd7) ns = READ_NACK;
          READ_NACK: ns = STOP;
          STOP:      ns = IDLE;
          default:   ns = IDLE;
        endcase
      end
    end
  end

  // line levels for the cycle being entered
  always_comb begin
    scl_n = 1'b1;
    sda_n = 1'b1;
    unique case (ns)
      START: sda_n = !nq[1];
      ADDR: begin
        scl_n = nq[1];
        sda_n = abyte[~nbit];
      end
      WRITE: begin
        scl_n = nq[1];
        sda_n = data_q[~nbit];
      end
      ADDR_ACK, WRITE_ACK, READ, READ_NACK: scl_n = nq[1];
      STOP: begin
        scl_n = nq[1];
        sda_n = (nq == 2'd3);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      q         <= 2'd0;
      bitc      <= 3'd0;
      addr_q    <= 7'h00;
      rw_q      <= 1'b0;
      data_q    <= 8'h00;
      rx        <= 8'h00;
      data_out  <= 8'h00;
      done      <= 1'b0;
      ack_error <= 1'b0;
      SCL_out   <= 1'b1;
      SDA_out   <= 1'b1;
      sda_m     <= 1'b1;
      sda_s     <= 1'b1;
    end else begin
      state   <= ns;
      cnt     <= ncnt;
      q       <= nq;
      bitc    <= nbit;
      SCL_out <= scl_n;
      SDA_out <= sda_n;
      sda_m   <= SDA_in;
      sda_s   <= sda_m;
      done    <= (state == STOP) && slot_end;
      if (accept) begin
        addr_q    <= addr;
        rw_q      <= rw;
        data_q    <= data_in;
        ack_error <= 1'b0;
      end
      if (smp) begin
        if ((state == ADDR_ACK || state == WRITE_ACK) && sda_s)
          ack_error <= 1'b1;
        if (state == READ) begin
          rx <= {rx[6:0], sda_s};
          if (bitc == 3'd7)
            data_out <= {rx[6:0], sda_s};
        end
      end
    end
  end

endmodule

// File: tb/tb_i2c_master.sv
// Bench for i2c_master: slot-level waveform model acting as both
// reference and I2C target, checked every cycle on the falling edge.
module tb_i2c_master;

  localparam int D  = 4;
  localparam int SL = 4 * D;
  localparam int K_START = 0;
  localparam int K_DATA  = 1;
  localparam int K_REL   = 2;
  localparam int K_STOP  = 3;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       SDA_in, SDA_out, SCL_out;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [6:0] addr = 7'h00;
  logic       rw = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [7:0] data_out;
  logic       done, ack_error, busy;
  logic       tgt = 1'b1;

  assign SDA_in = SDA_out & tgt;

  always #5 clock = ~clock;

  i2c_master #(.CLK_DIV(D)) dut (
    .clock(clock), .reset(reset),
    .SDA_in(SDA_in), .SDA_out(SDA_out), .SCL_out(SCL_out),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .addr(addr), .rw(rw), .data_in(data_in),
    .data_out(data_out), .done(done),
    .ack_error(ack_error), .busy(busy)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // target behaviour for the next accepted command
  bit         t_aa = 1'b1;
  bit         t_ad = 1'b1;
  logic [7:0] t_rb = 8'h00;

  // model: slot list of the running transaction
  int         m_k = 0;
  int         m_n = 0;
  int         kind [20];
  bit         mb [20];
  bit         tb [20];
  bit         m_ackerr = 1'b0;
  logic [7:0] m_dout = 8'h00;
  logic [7:0] mab;

  task automatic add_slot(input int k, input bit m, input bit t);
    kind[m_n] = k;
    mb[m_n]   = m;
    tb[m_n]   = t;
    m_n++;
  endtask

  initial forever begin
    @(posedge clock or posedge reset);
    if (reset) begin
      m_k = 0;
      m_ackerr = 1'b0;
      m_dout = 8'h00;
    end else if (m_k == 0) begin
      if (cmd_valid) begin
        mab = {addr, rw};
        m_n = 0;
        add_slot(K_START, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) add_slot(K_DATA, mab[7-i], 1'b1);
        add_slot(K_REL, 1'b1, !t_aa);
        m_ackerr = !t_aa;
        if (t_aa && !rw) begin
          for (int i = 0; i < 8; i++) add_slot(K_DATA, data_in[7-i], 1'b1);
          add_slot(K_REL, 1'b1, !t_ad);
          m_ackerr = !t_ad;
        end else if (t_aa) begin
          for (int i = 0; i < 8; i++) add_slot(K_REL, 1'b1, t_rb[7-i]);
          add_slot(K_REL, 1'b1, 1'b1);
          m_dout = t_rb;
        end
        add_slot(K_STOP, 1'b1, 1'b1);
        m_k = 1;
      end
    end else if (m_k == m_n * SL + 1) begin
      m_k = 0;
    end else begin
      m_k++;
    end
  end

  // per-cycle compare and target drive
  initial begin
    int  s, qq;
    bit  escl, esda, edone, erdy, tg, prev_scl, prev_sda;
    prev_scl = 1'b1;
    prev_sda = 1'b1;
    forever begin
      @(negedge clock);
      escl = 1'b1; esda = 1'b1; edone = 1'b0; erdy = 1'b1; tg = 1'b1;
      s = 0;
      if (m_k != 0 && m_k == m_n * SL + 1) begin
        edone = 1'b1;
        erdy  = 1'b0;
      end else if (m_k != 0) begin
        erdy = 1'b0;
        s    = (m_k - 1) / SL;
        qq   = ((m_k - 1) / D) % 4;
        case (kind[s])
          K_START: esda = (qq < 2);
          K_DATA: begin escl = (qq >= 2); esda = mb[s]; end
          K_REL:  begin escl = (qq >= 2); tg = tb[s]; end
          default: begin escl = (qq >= 2); esda = (qq == 3); end
        endcase
      end
      tgt = tg;
      chk("scl", 32'(SCL_out), 32'(escl));
      chk("sda", 32'(SDA_out), 32'(esda));
      chk("done", 32'(done), 32'(edone));
      chk("cmd_ready", 32'(cmd_ready), 32'(erdy));
      chk("busy", 32'(busy), 32'(!erdy));
      if (m_k == 0 || edone) begin
        chk("ack_error", 32'(ack_error), 32'(m_ackerr));
        chk("data_out", 32'(data_out), 32'(m_dout));
      end
      if (m_k > 1 && !edone && (kind[s] == K_DATA || kind[s] == K_REL)
          && prev_scl && SCL_out)
        chk("sda_stable_scl_high", 32'(SDA_out), 32'(prev_sda));
      prev_scl = SCL_out;
      prev_sda = SDA_out;
    end
  end

  task automatic issue(input logic [6:0] a, input logic r,
                       input logic [7:0] d, input bit aa, input bit ad,
                       input logic [7:0] rb, input bit hold,
                       output int w, output int lat);
    addr = a; rw = r; data_in = d;
    t_aa = aa; t_ad = ad; t_rb = rb;
    cmd_valid = 1'b1;
    w = 0;
    lat = 0;
    @(negedge clock);
    while (!cmd_ready && w < 1000) begin
      w++;
      @(negedge clock);
    end
    if (w >= 1000) begin
      errors++;
      checks++;
      $display("FAIL accept_timeout: waited %0d cycles", w);
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clock);
    #2;
    if (!hold) cmd_valid = 1'b0;
    addr = ~a; rw = ~r; data_in = ~d;
    do begin
      @(negedge clock);
      lat++;
    end while (!done && lat < 2000);
  endtask

  initial begin
    int w, lat, nd;
    repeat (2) @(negedge clock);
    chk("rst_scl", 32'(SCL_out), 32'd1);
    chk("rst_sda", 32'(SDA_out), 32'd1);
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_dout", 32'(data_out), 32'h00);
    chk("rst_ackerr", 32'(ack_error), 32'd0);
    @(posedge clock);
    #2 reset = 1'b0;

    issue(7'h49, 1'b0, 8'hA5, 1'b1, 1'b1, 8'h00, 1'b0, w, lat);
    chk("first_accept_wait", 32'(w), 32'd0);
    chk("wr_latency", 32'(lat), 32'd321);
    chk("wr_ackerr", 32'(ack_error), 32'd0);

    issue(7'h22, 1'b0, 8'h5A, 1'b0, 1'b1, 8'h00, 1'b0, w, lat);
    chk("nack_latency", 32'(lat), 32'd177);
    chk("nack_ackerr", 32'(ack_error), 32'd1);

    issue(7'h49, 1'b1, 8'h00, 1'b1, 1'b1, 8'h3C, 1'b0, w, lat);
    chk("rd_latency", 32'(lat), 32'd321);
    chk("rd_data", 32'(data_out), 32'h3C);
    chk("rd_ackerr", 32'(ack_error), 32'd0);

    issue(7'h6B, 1'b0, 8'hFF, 1'b1, 1'b0, 8'h00, 1'b0, w, lat);
    chk("wdnack_latency", 32'(lat), 32'd321);
    chk("wdnack_ackerr", 32'(ack_error), 32'd1);

    issue(7'h10, 1'b0, 8'h0F, 1'b1, 1'b1, 8'h00, 1'b1, w, lat);
    chk("b2b_first_latency", 32'(lat), 32'd321);
    issue(7'h7F, 1'b1, 8'h00, 1'b1, 1'b1, 8'h81, 1'b0, w, lat);
    chk("b2b_gap", 32'(w), 32'd0);
    chk("b2b_second_latency", 32'(lat), 32'd321);
    chk("b2b_data", 32'(data_out), 32'h81);

    addr = 7'h55; rw = 1'b0; data_in = 8'hC3;
    t_aa = 1'b1; t_ad = 1'b1;
    cmd_valid = 1'b1;
    @(negedge clock);
    chk("rstmid_ready", 32'(cmd_ready), 32'd1);
    @(posedge clock);
    #2 cmd_valid = 1'b0;
    repeat (13 * SL + 5) @(negedge clock);
    #1 reset = 1'b1;
    #1;
    chk("rstmid_scl", 32'(SCL_out), 32'd1);
    chk("rstmid_sda", 32'(SDA_out), 32'd1);
    chk("rstmid_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rstmid_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clock);
    #1 reset = 1'b0;
    nd = 0;
    repeat (400) begin
      @(negedge clock);
      if (done) nd++;
    end
    chk("rstmid_no_done", 32'(nd), 32'd0);

    issue(7'h31, 1'b1, 8'h00, 1'b0, 1'b1, 8'hEE, 1'b0, w, lat);
    chk("rdnack_latency", 32'(lat), 32'd177);
    chk("rdnack_ackerr", 32'(ack_error), 32'd1);
    chk("rdnack_dout_held", 32'(data_out), 32'h00);

    repeat (4) @(negedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

endmodule
